s2p_frame: RTL and testbench

Serial-to-parallel frame collector for the 8-point FFT datapath: accepts one 16-bit sample per handshake, assembles eight consecutive samples into a frame and presents them as eight parallel 16-bit words to the butterfly stage. It is the input-side counterpart of the output serialiser. It adds valid/ready flow control and frame-start resynchronisation.

---
 rtl/s2p_frame.sv | 105 ++++++++++
 tb/tb_s2p_frame.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_frame.sv
// s2p_frame: gathers eight 16-bit samples into one parallel frame, with valid/ready on both sides and in_sof resync.
// Define S2P_BITREV_EN to load the output bank in 3-bit bit-reversed (DIT) order instead of natural order.
module s2p_frame (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_sof,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] y1,
   output logic [15:0] y2,
   output logic [15:0] y3,
   output logic [15:0] y4,
   output logic [15:0] y5,
   output logic [15:0] y6,
   output logic [15:0] y7,
   output logic [15:0] y8,
   output logic        sync_err
);

   logic [2:0]  cnt;
   logic [15:0] cap   [0:6];
   logic [15:0] frame [0:7];
   logic        accept;
   logic        last;

   // Stall only sample 7, and only while the previous frame is still unconsumed.
   assign in_ready = !(cnt == 3'd7 && out_valid);
   assign accept   = in_valid && in_ready;
   assign last     = accept && !in_sof && (cnt == 3'd7);

   always_comb begin
      for (int k = 0; k < 7; k++) begin
         frame[k] = cap[k];
      end
      frame[7] = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 3'd0;
         sync_err <= 1'b0;
         for (int k = 0; k < 7; k++) begin
            cap[k] <= 16'd0;
         end
      end else begin
         sync_err <= 1'b0;
         if (accept) begin
            if (in_sof) begin
               cap[0]   <= in_data;
               cnt      <= 3'd1;
               sync_err <= (cnt != 3'd0);
            end else begin
               for (int k = 0; k < 7; k++) begin
                  if (cnt == 3'(k)) begin
                     cap[k] <= in_data;
                  end
               end
               cnt <= cnt + 3'd1;
            end
         end
      end
   end

   // A load can only happen with out_valid low, so it never collides with consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y1 <= 16'd0;
         y2 <= 16'd0;
         y3 <= 16'd0;
         y4 <= 16'd0;
         y5 <= 16'd0;
         y6 <= 16'd0;
         y7 <= 16'd0;
         y8 <= 16'd0;
      end else if (last) begin
         out_valid <= 1'b1;
`ifdef S2P_BITREV_EN
         y1 <= frame[0];
         y2 <= frame[4];
         y3 <= frame[2];
         y4 <= frame[6];
         y5 <= frame[1];
         y6 <= frame[5];
         y7 <= frame[3];
         y8 <= frame[7];
`else
         y1 <= frame[0];
         y2 <= frame[1];
         y3 <= frame[2];
         y4 <= frame[3];
         y5 <= frame[4];
         y6 <= frame[5];
         y7 <= frame[6];
         y8 <= frame[7];
`endif
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_s2p_frame.sv
// Bench for s2p_frame: directed table, hand-written corner sequences and random traffic against a queue-based model.
module tb_s2p_frame;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_sof;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y1, y2, y3, y4, y5, y6, y7, y8;
   logic        sync_err;
   logic [15:0] yv [8];

   int checks = 0;
   int errors = 0;

   s2p_frame dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
      .out_valid(out_valid), .out_ready(out_ready),
      .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7), .y8(y8),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   always_comb begin
      yv[0] = y1; yv[1] = y2; yv[2] = y3; yv[3] = y4;
      yv[4] = y5; yv[5] = y6; yv[6] = y7; yv[7] = y8;
   end

   // Model: partial frame as a queue of accepted samples, plus one pending output frame.
   logic [15:0] part [$];
   logic [15:0] my [8];
   bit          mpend;
   bit          mse;

   function automatic int pos(input int k);
`ifdef S2P_BITREV_EN
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
      return k;
`endif
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      part.delete();
      for (int k = 0; k < 8; k++) my[k] = 16'd0;
      mpend = 1'b0;
      mse   = 1'b0;
   endtask

   task automatic check_all();
      chk1("out_valid", out_valid, mpend);
      chk1("sync_err", sync_err, mse);
      for (int k = 0; k < 8; k++) chk16($sformatf("y%0d", k + 1), yv[k], my[k]);
   endtask

   task automatic cyc(input logic v, input logic sof, input logic [15:0] d, input logic ordy,
                      output logic rdy_seen);
      bit mr;
      in_valid  = v;
      in_sof    = sof;
      in_data   = d;
      out_ready = ordy;
      mr = !(part.size() == 7 && mpend);
      rdy_seen = in_ready;
      chk1("in_ready", in_ready, mr);
      @(posedge clk);
      mse = 1'b0;
      if (mpend && ordy) mpend = 1'b0;
      if (v && mr) begin
         if (sof) begin
            mse = (part.size() != 0);
            part.delete();
            part.push_back(d);
         end else begin
            part.push_back(d);
            if (part.size() == 8) begin
               for (int k = 0; k < 8; k++) my[k] = part[pos(k)];
               mpend = 1'b1;
               part.delete();
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic cy(input logic v, input logic sof, input logic [15:0] d, input logic ordy);
      logic r;
      cyc(v, sof, d, ordy, r);
   endtask

   typedef struct {
      logic        v;
      logic        sof;
      logic [15:0] d;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic        e_se;
      logic [15:0] e_y1;
      logic [15:0] e_y8;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input logic v, input logic sof, input logic [15:0] d, input logic ordy,
                               input logic e_rdy, input logic e_ov, input logic e_se,
                               input logic [15:0] e_y1, input logic [15:0] e_y8);
      vec_t t;
      t.v = v; t.sof = sof; t.d = d; t.ordy = ordy;
      t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_se = e_se; t.e_y1 = e_y1; t.e_y8 = e_y8;
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic        r;
      logic [15:0] exp_mid [6];

      // Frame 0x0001..0x0008, out_ready high throughout.
      tbl.push_back(mk(1, 1, 16'h0001, 1, 1, 0, 0, 16'h0000, 16'h0000));
      for (int i = 1; i < 7; i++)
         tbl.push_back(mk(1, 0, 16'(i + 1), 1, 1, 0, 0, 16'h0000, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0008, 1, 1, 1, 0, 16'h0001, 16'h0008));
      tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 16'h0001, 16'h0008));
      // Partial frame abandoned by an in_sof.
      tbl.push_back(mk(1, 1, 16'hAAAA, 1, 1, 0, 0, 16'h0001, 16'h0008));
      tbl.push_back(mk(1, 0, 16'hBBBB, 1, 1, 0, 0, 16'h0001, 16'h0008));
      tbl.push_back(mk(1, 0, 16'hCCCC, 1, 1, 0, 0, 16'h0001, 16'h0008));
      tbl.push_back(mk(1, 1, 16'h1000, 1, 1, 0, 1, 16'h0001, 16'h0008));
      for (int i = 1; i < 7; i++)
         tbl.push_back(mk(1, 0, 16'(16'h1000 + i), 1, 1, 0, 0, 16'h0001, 16'h0008));
      tbl.push_back(mk(1, 0, 16'h1007, 1, 1, 1, 0, 16'h1000, 16'h1007));
      tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 16'h1000, 16'h1007));

`ifdef S2P_BITREV_EN
      exp_mid = '{16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3};
`else
      exp_mid = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
`endif

      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 16'd0; out_ready = 1'b0;
      model_reset();
      #2;
      chk1("reset_in_ready", in_ready, 1'b1);
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].ordy, r);
         chk1($sformatf("tbl%0d_rdy", i), r, tbl[i].e_rdy);
         chk1($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
         chk1($sformatf("tbl%0d_se", i), sync_err, tbl[i].e_se);
         chk16($sformatf("tbl%0d_y1", i), y1, tbl[i].e_y1);
         chk16($sformatf("tbl%0d_y8", i), y8, tbl[i].e_y8);
      end

      // Backpressure: second frame's sample 7 must wait for the first frame to be taken.
      cy(1, 1, 16'h0010, 0);
      for (int i = 1; i < 8; i++) cy(1, 0, 16'(16'h0010 + i), 0);
      cy(1, 1, 16'h0020, 0);
      for (int i = 1; i < 7; i++) cy(1, 0, 16'(16'h0020 + i), 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 16'h0027, 0, r);
         chk1("bp_stall_rdy", r, 1'b0);
         chk16("bp_stall_y1", y1, 16'h0010);
      end
      cyc(1, 0, 16'h0027, 1, r);
      chk1("bp_consume_rdy", r, 1'b0);
      chk1("bp_consume_ov", out_valid, 1'b0);
      cyc(1, 0, 16'h0027, 0, r);
      chk1("bp_accept_rdy", r, 1'b1);
      chk1("bp_accept_ov", out_valid, 1'b1);
      chk16("bp_y1", y1, 16'h0020);
      chk16("bp_y8", y8, 16'h0027);
      cy(0, 0, 16'h0000, 1);

      // Output ordering with samples equal to their index.
      cy(1, 1, 16'h0000, 1);
      for (int i = 1; i < 8; i++) cy(1, 0, 16'(i), 1);
      for (int k = 0; k < 6; k++) chk16($sformatf("order_y%0d", k + 2), yv[k + 1], exp_mid[k]);
      cy(0, 0, 16'h0000, 1);

      // Reset with a frame pending and a partial frame in capture.
      cy(1, 1, 16'h0030, 0);
      for (int i = 1; i < 8; i++) cy(1, 0, 16'(16'h0030 + i), 0);
      cy(1, 1, 16'h0040, 0);
      for (int i = 1; i < 5; i++) cy(1, 0, 16'(16'h0040 + i), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst_mid_ov", out_valid, 1'b0);
      chk1("rst_mid_rdy", in_ready, 1'b1);
      chk16("rst_mid_y1", y1, 16'h0000);
      chk16("rst_mid_y8", y8, 16'h0000);
      model_reset();
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cy(1, 1, 16'h0050, 1);
      for (int i = 1; i < 8; i++) cy(1, 0, 16'(16'h0050 + i), 1);
      chk16("post_rst_y1", y1, 16'h0050);
      chk1("post_rst_ov", out_valid, 1'b1);
      cy(0, 0, 16'h0000, 1);

      // in_valid toggling: eight samples over fifteen cycles.
      for (int i = 0; i < 15; i++) begin
         cy((i % 2) == 0, i == 0, 16'(16'hF000 + i / 2), 1);
         chk1($sformatf("toggle_ov%0d", i), out_valid, i == 14);
      end
      chk16("toggle_y8", y8, 16'hF007);
      cy(0, 0, 16'h0000, 1);

      // Random traffic with alternating phases of sparse and dense out_ready.
      for (int i = 0; i < 3000; i++) begin
         logic ordy;
         if (((i / 60) % 3) == 2) ordy = ($urandom_range(0, 9) == 0);
         else                     ordy = ($urandom_range(0, 2) != 0);
         cy($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 16'($urandom), ordy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
